lut3d_cfg_loader: RTL and testbench
===================================

# lut3d_cfg_loader

Controller that sequences loading of a full 3D LUT into the trilinear color-mapping LUT RAM. It accepts LUT entries from a host stream with valid/ready handshake and waits for vertical blanking before starting a load. It produces the `cfg_data/cfg_valid/cfg_last` write sequence that the LUT RAM expects, and checks the entry count against the host's `last` marker. It sits between the host/DMA side and the `color_mapping_3dlut` config port, in the pixel clock domain.

## Interface
- `GS`, 33: grid size (17, 33 or 65); N = GS³ entries per load.
- `LUT_CD`, 8: LUT entry color depth; entry width is 3·LUT_CD.
- `WAIT_VS`, 1: when 1, a load starts only at a rising edge of `i_vs`; when 0, it starts immediately.
- `CW`, $clog2(GS³+1): entry counter width.

- `p_clk`  in  1  pixel clock.
- `p_rstn`  in  1  reset p_rstn, asynchronous, active-low; clock p_clk.
- `i_start`  in  1  pulse; requests a load. Ignored unless the block is IDLE.
- `i_abort`  in  1  level; cancels an armed or in-progress load.
- `i_vs`  in  1  video vsync, already synchronous to `p_clk`.
- `s_data`  in  3·LUT_CD  LUT entry, R in the LSBs.
- `s_valid`  in  1  entry valid.
- `s_last`  in  1  host marks the final entry.
- `s_ready`  out  1  block accepts an entry.
- `o_cfg_data`  out  3·LUT_CD  entry to the LUT RAM.
- `o_cfg_valid`  out  1  write strobe.
- `o_cfg_last`  out  1  final-entry strobe, coincident with `o_cfg_valid`.
- `o_busy`  out  1  high in ARM and LOAD.
- `o_done`  out  1  1-cycle pulse on successful completion.
- `o_err`  out  1  sticky error flag.
- `o_err_code`  out  2  error code: 0 none, 1 short, 2 long, 3 abort.
- `i_err_clr`  in  1  pulse; clears `o_err` and `o_err_code`.
- `o_entry_cnt`  out  CW  entries accepted in the current or last load.

## Operation
- States: IDLE, ARM, LOAD, DONE.
- IDLE:
  - `i_start` → ARM (if WAIT_VS=1) or LOAD (if WAIT_VS=0).
  - `o_entry_cnt` clears to 0 on that transition.
- ARM:
  - Registered `vs_d`; a rising edge is `i_vs & ~vs_d`.
  - A rising edge → LOAD.
  - `i_abort` → IDLE with error 3; abort wins over a simultaneous edge.
- LOAD:
  - `s_ready = (state==LOAD) & ~i_abort`.
  - A handshake (`s_valid & s_ready`) increments the counter and registers the entry onto `o_cfg_data` with `o_cfg_valid=1`.
  - Entry index N−1: `o_cfg_last=1`, next state DONE. If `s_last` is 0 on that entry, error 2 is set; the load still completes and `o_done` pulses.
  - `s_last=1` on index < N−1: the entry is written with `o_cfg_last=0`, error 1 is set, next state IDLE, and `o_done` does not pulse.
  - `i_abort`: no entry is accepted that cycle, error 3 is set, next state IDLE, and `o_cfg_last` is never issued.
- DONE: `o_done=1` for one cycle, then IDLE.
- Error register:
  - The first error is kept: a new error is recorded only while `o_err=0`.
  - `i_err_clr` in the same cycle as a new error: the new error wins.
  - Errors do not block a later `i_start`.
- Counter arithmetic: unsigned CW bits; it never exceeds N because LOAD exits at N.

## Timing
- Reset values: state IDLE, and `s_ready`, `o_cfg_valid`, `o_cfg_last`, `o_busy`, `o_done`, `o_err` all 0. `o_err_code`, `o_cfg_data`, `o_entry_cnt` and `vs_d` are 0.
- `i_start` at cycle t → ARM at t+1.
- Rising vs edge visible at cycle t → LOAD at t+1; `s_ready` is high at t+1 (combinational from state).
- Handshake at cycle t → `o_cfg_valid`/`o_cfg_data` at t+1, for one cycle only. Full throughput of one entry per cycle.
- Last handshake at cycle t → `o_cfg_last` at t+1, `o_done` at t+2, IDLE at t+3.
- `o_busy` is registered from state and follows state in the same cycle.
- Reset asserted mid-load: all outputs drop immediately (async). The RAM contents are then undefined until the next full load.

## Test plan
- Nominal: GS=17, WAIT_VS=1. Start, then vs rising edge, then 4913 back-to-back entries with `s_last` on the last → 4913 `o_cfg_valid` pulses, `o_cfg_last` on the 4913th, `o_done` one cycle later, `o_err`=0, `o_entry_cnt`=4913.
- Vsync gating: start with `i_vs` held high, then low for 10 cycles, then high → `s_ready` stays 0 until the cycle after the 0→1 edge.
- Short load: `s_last` on entry 100 → 100 writes, no `o_cfg_last`, no `o_done`, `o_err_code`=1, block returns to IDLE.
- Long load: no `s_last` on entry 4913 → `o_cfg_last` still issued, `o_done` pulses, `o_err_code`=2; `s_ready` drops after entry 4913.
- Abort in LOAD, same cycle as `s_valid`, after 50 entries → that entry is not accepted, `o_entry_cnt`=50, `o_err_code`=3. A subsequent `i_err_clr` returns `o_err` to 0.
- Random `s_valid` gaps plus `i_start` pulses issued during LOAD → the `i_start` pulses are ignored, the data sequence on `o_cfg_data` matches the input order exactly, and the write count is 4913.

Source files
------------

// File: rtl/lut3d_cfg_loader_if.sv
// Host-side LUT entry stream: one entry per valid/ready handshake.
// The last flag marks the final entry of a load.
`timescale 1ns/1ps
interface lut3d_cfg_loader_if #(
  parameter int DW = 24
) ();
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/lut3d_cfg_loader.sv
// Sequences a full 3D LUT load from the host stream into the LUT RAM config port,
// optionally gated on a vsync rising edge, with entry-count checking against s_last.
`timescale 1ns/1ps
module lut3d_cfg_loader #(
  parameter int GS      = 33,
  parameter int LUT_CD  = 8,
  parameter bit WAIT_VS = 1'b1,
  parameter int CW      = $clog2(GS*GS*GS+1)
) (
  input  logic                p_clk,
  input  logic                p_rstn,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_vs,
  lut3d_cfg_loader_if.slave   s_if,
  output logic [3*LUT_CD-1:0] o_cfg_data,
  output logic                o_cfg_valid,
  output logic                o_cfg_last,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [1:0]          o_err_code,
  input  logic                i_err_clr,
  output logic [CW-1:0]       o_entry_cnt
);

  localparam int            N        = GS*GS*GS;
  localparam logic [CW-1:0] LAST_IDX = CW'(N-1);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  typedef enum logic [1:0] {IDLE, ARM, LOAD, DONE} state_t;

  state_t               state_q;
  logic                 vs_q;
  logic [3*LUT_CD-1:0]  cfg_data_q;
  logic                 cfg_valid_q;
  logic                 cfg_last_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [1:0]           err_code_q;
  logic [CW-1:0]        cnt_q;

  logic                 s_ready_int;
  logic                 hs;
  logic                 hs_final;
  logic                 vs_rise;
  logic                 err_evt;
  logic [1:0]           err_evt_code;
  logic                 err_d;
  logic [1:0]           err_code_d;

  // Abort masks ready so the entry offered in the abort cycle is never taken.
  assign s_ready_int = (state_q == LOAD) & ~i_abort;
  assign s_if.s_ready = s_ready_int;
  assign hs       = s_if.s_valid & s_ready_int;
  assign hs_final = hs & (cnt_q == LAST_IDX);
  assign vs_rise  = i_vs & ~vs_q;

  always_comb begin
    err_evt      = 1'b0;
    err_evt_code = ERR_NONE;
    case (state_q)
      ARM: begin
        if (i_abort) begin
          err_evt      = 1'b1;
          err_evt_code = ERR_ABORT;
        end
      end
      LOAD: begin
        if (i_abort) begin
          err_evt      = 1'b1;
          err_evt_code = ERR_ABORT;
        end else if (hs_final && !s_if.s_last) begin
          err_evt      = 1'b1;
          err_evt_code = ERR_LONG;
        end else if (hs && !hs_final && s_if.s_last) begin
          err_evt      = 1'b1;
          err_evt_code = ERR_SHORT;
        end
      end
      default: ;
    endcase
  end

  // First error sticks; a clear arriving with a new error lets the new one land.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    if (err_evt && (!err_q || i_err_clr)) begin
      err_d      = 1'b1;
      err_code_d = err_evt_code;
    end else if (i_err_clr) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end
  end

  always_ff @(posedge p_clk or negedge p_rstn) begin
    if (!p_rstn) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      cfg_data_q  <= '0;
      cfg_valid_q <= 1'b0;
      cfg_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      cnt_q       <= '0;
    end else begin
      vs_q        <= i_vs;
      cfg_valid_q <= 1'b0;
      cfg_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= err_d;
      err_code_q  <= err_code_d;

      if (hs) begin
        cfg_data_q  <= s_if.s_data;
        cfg_valid_q <= 1'b1;
        cnt_q       <= cnt_q + CW'(1);
      end

      case (state_q)
        IDLE: begin
          if (i_start) begin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= WAIT_VS ? ARM : LOAD;
          end
        end
        ARM: begin
          if (i_abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (vs_rise) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (i_abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (hs_final) begin
            cfg_last_q <= 1'b1;
            state_q    <= DONE;
            busy_q     <= 1'b0;
          end else if (hs && s_if.s_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          // Two cycles here: the o_cfg_last cycle, then the o_done cycle.
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cfg_data  = cfg_data_q;
  assign o_cfg_valid = cfg_valid_q;
  assign o_cfg_last  = cfg_last_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_err_code  = err_code_q;
  assign o_entry_cnt = cnt_q;

endmodule

// File: tb/tb_lut3d_cfg_loader.sv
// Directed bench for lut3d_cfg_loader with GS=17 (4913 entries) and vsync gating enabled.
`timescale 1ns/1ps
module tb_lut3d_cfg_loader;
  localparam int GS     = 17;
  localparam int LUT_CD = 8;
  localparam int DW     = 3*LUT_CD;
  localparam int N      = GS*GS*GS;
  localparam int CW     = $clog2(N+1);

  logic          p_clk = 1'b0;
  logic          p_rstn = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          i_vs = 1'b0;
  logic          i_err_clr = 1'b0;
  logic [DW-1:0] o_cfg_data;
  logic          o_cfg_valid;
  logic          o_cfg_last;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [1:0]    o_err_code;
  logic [CW-1:0] o_entry_cnt;

  lut3d_cfg_loader_if #(.DW(DW)) s_if ();

  lut3d_cfg_loader #(.GS(GS), .LUT_CD(LUT_CD), .WAIT_VS(1'b1), .CW(CW)) dut (
    .p_clk       (p_clk),
    .p_rstn      (p_rstn),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_vs        (i_vs),
    .s_if        (s_if),
    .o_cfg_data  (o_cfg_data),
    .o_cfg_valid (o_cfg_valid),
    .o_cfg_last  (o_cfg_last),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_err_code  (o_err_code),
    .i_err_clr   (i_err_clr),
    .o_entry_cnt (o_entry_cnt)
  );

  always #5 p_clk = ~p_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge p_clk) cyc <= cyc + 1;

  // Write log of the config port, sampled mid-cycle.
  logic [DW-1:0] got_q[$];
  int n_last      = 0;
  int n_done      = 0;
  int last_wr_idx = -1;
  int last_cyc    = 0;
  int done_cyc    = 0;

  always @(negedge p_clk) begin
    if (o_cfg_valid === 1'b1) got_q.push_back(o_cfg_data);
    if (o_cfg_last === 1'b1) begin
      n_last      <= n_last + 1;
      last_wr_idx <= got_q.size() - 1;
      last_cyc    <= cyc;
    end
    if (o_done === 1'b1) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  function automatic logic [DW-1:0] exp_entry(input int i);
    logic [7:0] r, g, b;
    r = i[7:0];
    g = i[15:8] ^ 8'h5A;
    b = 8'(i*7);
    return {b, g, r};
  endfunction

  task automatic launch();
    @(negedge p_clk); i_vs = 1'b0; i_start = 1'b1;
    @(negedge p_clk); i_start = 1'b0; i_vs = 1'b1;
    @(negedge p_clk); i_vs = 1'b0;
  endtask

  // Offers entries until n are accepted or the cycle budget runs out.
  task automatic drive_stream(input int n, input int last_at, input bit gaps,
                              input bit start_noise, output int acc);
    int budget;
    bit take;
    acc = 0;
    budget = n*4 + 100;
    while (acc < n && budget > 0) begin
      @(negedge p_clk);
      budget--;
      s_if.s_valid = (gaps && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      s_if.s_data  = exp_entry(acc);
      s_if.s_last  = (acc == last_at);
      i_start      = start_noise && ($urandom_range(0, 15) == 0);
      #1;
      take = s_if.s_valid & s_if.s_ready;
      @(posedge p_clk);
      if (take) acc++;
    end
    @(negedge p_clk);
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    i_start      = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (s_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_if.s_ready); end
    n_checks++; if (o_cfg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_valid: got %b want 0", o_cfg_valid); end
    n_checks++; if (o_cfg_last !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_last: got %b want 0", o_cfg_last); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_err); end
    n_checks++; if (o_err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d want 0", o_err_code); end
    n_checks++; if (o_cfg_data !== '0) begin n_fail++; $display("FAIL reset_cfg_data: got %h want 0", o_cfg_data); end
    n_checks++; if (o_entry_cnt !== '0) begin n_fail++; $display("FAIL reset_entry_cnt: got %0d want 0", o_entry_cnt); end
    @(negedge p_clk); p_rstn = 1'b1;
  endtask

  // Leaves the block in LOAD for test_nominal.
  task automatic test_vs_gating();
    int ready_seen;
    ready_seen = 0;
    @(negedge p_clk); i_vs = 1'b1; i_start = 1'b1;
    @(negedge p_clk); i_start = 1'b0;
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL arm_busy: got %b want 1", o_busy); end
    repeat (3) begin
      @(negedge p_clk);
      if (s_if.s_ready !== 1'b0) ready_seen++;
    end
    i_vs = 1'b0;
    repeat (10) begin
      @(negedge p_clk);
      if (s_if.s_ready !== 1'b0) ready_seen++;
    end
    n_checks++; if (ready_seen != 0) begin n_fail++; $display("FAIL arm_ready_held: ready cycles %0d want 0", ready_seen); end
    i_vs = 1'b1;
    #1;
    n_checks++; if (s_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL vs_edge_cycle_ready: got %b want 0", s_if.s_ready); end
    @(negedge p_clk);
    n_checks++; if (s_if.s_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1", s_if.s_ready); end
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b want 1", o_busy); end
    i_vs = 1'b0;
  endtask

  task automatic test_nominal();
    int base, lbase, dbase, acc, mism;
    base = got_q.size(); lbase = n_last; dbase = n_done;
    drive_stream(N, N-1, 1'b0, 1'b0, acc);
    repeat (3) @(negedge p_clk);
    mism = 0;
    for (int k = 0; k < N; k++) if (got_q[base+k] !== exp_entry(k)) mism++;
    n_checks++; if (acc != N) begin n_fail++; $display("FAIL nom_accepted: got %0d want %0d", acc, N); end
    n_checks++; if (got_q.size() - base != N) begin n_fail++; $display("FAIL nom_writes: got %0d want %0d", got_q.size() - base, N); end
    n_checks++; if (mism != 0) begin n_fail++; $display("FAIL nom_data: %0d mismatched entries want 0", mism); end
    n_checks++; if (n_last - lbase != 1) begin n_fail++; $display("FAIL nom_last_count: got %0d want 1", n_last - lbase); end
    n_checks++; if (last_wr_idx != base + N - 1) begin n_fail++; $display("FAIL nom_last_pos: got %0d want %0d", last_wr_idx, base + N - 1); end
    n_checks++; if (n_done - dbase != 1) begin n_fail++; $display("FAIL nom_done_count: got %0d want 1", n_done - dbase); end
    n_checks++; if (done_cyc != last_cyc + 1) begin n_fail++; $display("FAIL nom_done_timing: got cycle %0d want %0d", done_cyc, last_cyc + 1); end
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL nom_err: got %b want 0", o_err); end
    n_checks++; if (o_entry_cnt !== CW'(N)) begin n_fail++; $display("FAIL nom_entry_cnt: got %0d want %0d", o_entry_cnt, N); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL nom_busy_after: got %b want 0", o_busy); end
  endtask

  // Leaves error code 1 set for test_arm_abort.
  task automatic test_short();
    int base, lbase, dbase, acc;
    launch();
    n_checks++; if (o_entry_cnt !== '0) begin n_fail++; $display("FAIL short_cnt_cleared: got %0d want 0", o_entry_cnt); end
    base = got_q.size(); lbase = n_last; dbase = n_done;
    drive_stream(100, 99, 1'b0, 1'b0, acc);
    repeat (3) @(negedge p_clk);
    n_checks++; if (acc != 100) begin n_fail++; $display("FAIL short_accepted: got %0d want 100", acc); end
    n_checks++; if (got_q.size() - base != 100) begin n_fail++; $display("FAIL short_writes: got %0d want 100", got_q.size() - base); end
    n_checks++; if (n_last - lbase != 0) begin n_fail++; $display("FAIL short_no_last: got %0d want 0", n_last - lbase); end
    n_checks++; if (n_done - dbase != 0) begin n_fail++; $display("FAIL short_no_done: got %0d want 0", n_done - dbase); end
    n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b want 1", o_err); end
    n_checks++; if (o_err_code !== 2'd1) begin n_fail++; $display("FAIL short_err_code: got %0d want 1", o_err_code); end
    n_checks++; if (o_entry_cnt !== CW'(100)) begin n_fail++; $display("FAIL short_entry_cnt: got %0d want 100", o_entry_cnt); end
    n_checks++; if (o_busy !== 1'b0 || s_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL short_idle: busy %b ready %b want 0 0", o_busy, s_if.s_ready); end
  endtask

  task automatic test_arm_abort();
    @(negedge p_clk); i_start = 1'b1;
    @(negedge p_clk); i_start = 1'b0; i_abort = 1'b1;
    @(negedge p_clk); i_abort = 1'b0;
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL arm_abort_busy: got %b want 0", o_busy); end
    n_checks++; if (o_err_code !== 2'd1) begin n_fail++; $display("FAIL first_err_kept: got %0d want 1", o_err_code); end
    // Abort with a simultaneous vsync edge and error clear.
    @(negedge p_clk); i_start = 1'b1;
    @(negedge p_clk); i_start = 1'b0; i_vs = 1'b1; i_abort = 1'b1; i_err_clr = 1'b1;
    @(negedge p_clk); i_vs = 1'b0; i_abort = 1'b0; i_err_clr = 1'b0;
    n_checks++; if (s_if.s_ready !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_vs: ready %b busy %b want 0 0", s_if.s_ready, o_busy); end
    n_checks++; if (o_err !== 1'b1 || o_err_code !== 2'd3) begin n_fail++; $display("FAIL new_err_beats_clr: err %b code %0d want 1 3", o_err, o_err_code); end
    @(negedge p_clk); i_err_clr = 1'b1;
    @(negedge p_clk); i_err_clr = 1'b0;
    n_checks++; if (o_err !== 1'b0 || o_err_code !== 2'd0) begin n_fail++; $display("FAIL err_clr: err %b code %0d want 0 0", o_err, o_err_code); end
  endtask

  task automatic test_long();
    int base, lbase, dbase, acc, ready_seen;
    launch();
    base = got_q.size(); lbase = n_last; dbase = n_done;
    drive_stream(N, -1, 1'b0, 1'b0, acc);
    ready_seen = 0;
    s_if.s_valid = 1'b1; s_if.s_data = exp_entry(N);
    repeat (5) begin
      #1;
      if (s_if.s_ready !== 1'b0) ready_seen++;
      @(negedge p_clk);
    end
    s_if.s_valid = 1'b0;
    n_checks++; if (acc != N) begin n_fail++; $display("FAIL long_accepted: got %0d want %0d", acc, N); end
    n_checks++; if (ready_seen != 0) begin n_fail++; $display("FAIL long_ready_after: ready cycles %0d want 0", ready_seen); end
    n_checks++; if (got_q.size() - base != N) begin n_fail++; $display("FAIL long_writes: got %0d want %0d", got_q.size() - base, N); end
    n_checks++; if (n_last - lbase != 1) begin n_fail++; $display("FAIL long_last_count: got %0d want 1", n_last - lbase); end
    n_checks++; if (n_done - dbase != 1) begin n_fail++; $display("FAIL long_done_count: got %0d want 1", n_done - dbase); end
    n_checks++; if (o_err !== 1'b1 || o_err_code !== 2'd2) begin n_fail++; $display("FAIL long_err: err %b code %0d want 1 2", o_err, o_err_code); end
    @(negedge p_clk); i_err_clr = 1'b1;
    @(negedge p_clk); i_err_clr = 1'b0;
  endtask

  task automatic test_abort_load();
    int base, lbase, dbase, acc;
    launch();
    base = got_q.size(); lbase = n_last; dbase = n_done;
    drive_stream(50, -1, 1'b0, 1'b0, acc);
    s_if.s_valid = 1'b1; s_if.s_data = exp_entry(50); i_abort = 1'b1;
    #1;
    n_checks++; if (s_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", s_if.s_ready); end
    @(negedge p_clk); i_abort = 1'b0; s_if.s_valid = 1'b0;
    repeat (2) @(negedge p_clk);
    n_checks++; if (o_entry_cnt !== CW'(50)) begin n_fail++; $display("FAIL abort_entry_cnt: got %0d want 50", o_entry_cnt); end
    n_checks++; if (got_q.size() - base != 50) begin n_fail++; $display("FAIL abort_writes: got %0d want 50", got_q.size() - base); end
    n_checks++; if (n_last - lbase != 0 || n_done - dbase != 0) begin n_fail++; $display("FAIL abort_no_last_done: last %0d done %0d want 0 0", n_last - lbase, n_done - dbase); end
    n_checks++; if (o_err_code !== 2'd3 || o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_code: code %0d busy %b want 3 0", o_err_code, o_busy); end
    @(negedge p_clk); i_err_clr = 1'b1;
    @(negedge p_clk); i_err_clr = 1'b0;
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL abort_err_clr: got %b want 0", o_err); end
  endtask

  task automatic test_back_to_back();
    int base, lbase, dbase, acc, mism;
    launch();
    base = got_q.size(); lbase = n_last; dbase = n_done;
    drive_stream(N, N-1, 1'b1, 1'b1, acc);
    repeat (3) @(negedge p_clk);
    mism = 0;
    for (int k = 0; k < N; k++) if (got_q[base+k] !== exp_entry(k)) mism++;
    n_checks++; if (got_q.size() - base != N) begin n_fail++; $display("FAIL gap_writes: got %0d want %0d", got_q.size() - base, N); end
    n_checks++; if (mism != 0) begin n_fail++; $display("FAIL gap_data_order: %0d mismatched entries want 0", mism); end
    n_checks++; if (n_last - lbase != 1 || n_done - dbase != 1) begin n_fail++; $display("FAIL gap_last_done: last %0d done %0d want 1 1", n_last - lbase, n_done - dbase); end
    n_checks++; if (o_entry_cnt !== CW'(N)) begin n_fail++; $display("FAIL gap_entry_cnt: got %0d want %0d", o_entry_cnt, N); end
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL gap_err: got %b want 0", o_err); end
  endtask

  task automatic test_async_reset();
    launch();
    @(negedge p_clk); s_if.s_valid = 1'b1; s_if.s_data = exp_entry(7);
    @(posedge p_clk); #2;
    s_if.s_valid = 1'b0;
    n_checks++; if (o_cfg_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", o_cfg_valid); end
    p_rstn = 1'b0;
    #1;
    n_checks++; if (o_cfg_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_outputs: valid %b busy %b want 0 0", o_cfg_valid, o_busy); end
    n_checks++; if (o_entry_cnt !== '0 || o_cfg_data !== '0) begin n_fail++; $display("FAIL async_reset_regs: cnt %0d data %h want 0 0", o_entry_cnt, o_cfg_data); end
    n_checks++; if (s_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready: got %b want 0", s_if.s_ready); end
    @(negedge p_clk); p_rstn = 1'b1;
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    s_if.s_data  = '0;
    test_reset();
    test_vs_gating();
    test_nominal();
    test_short();
    test_arm_abort();
    test_long();
    test_abort_load();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge p_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, test incomplete");
    $fatal(1, "watchdog");
  end

endmodule
